// File: rtl/perceptron_argmax.sv
// Frame-wise argmax over time-multiplexed perceptron scores with a clamped-step
// activation; one registered classification result per N_CLASSES samples.
module perceptron_argmax #(
    parameter int         N_CLASSES = 8,
    parameter logic [7:0] THRESH    = 8'd0,
    parameter int         IDX_W     = $clog2(N_CLASSES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [7:0]       out_value,
    output logic             out_fired
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    // Borrow-based compare keeps THRESH = 0 free of a constant-true comparison.
    function automatic logic [7:0] activate(input logic [7:0] x);
        logic [8:0] diff;
        diff = {1'b0, x} - {1'b0, THRESH};
        return diff[8] ? 8'd0 : x;
    endfunction

    logic [IDX_W-1:0] cnt;
    logic [7:0]       best_val;
    logic [IDX_W-1:0] best_idx;

    logic [7:0]       act;
    logic             is_last;
    logic             in_fire;
    logic             out_fire;
    logic             take;
    logic [7:0]       fin_val;
    logic [IDX_W-1:0] fin_idx;

    assign act      = activate(in_data);
    assign is_last  = (cnt == LAST_IDX);
    assign in_ready = !(is_last && out_valid && !out_ready);
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready;

    // Strict greater-than so ties keep the lowest class index.
    assign take    = (cnt == '0) || (act > best_val);
    assign fin_val = take ? act : best_val;
    assign fin_idx = take ? cnt : best_idx;

    // Running frame state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            best_val <= 8'd0;
            best_idx <= '0;
        end else if (flush) begin
            cnt      <= '0;
            best_val <= 8'd0;
            best_idx <= '0;
        end else if (in_fire) begin
            best_val <= fin_val;
            best_idx <= fin_idx;
            cnt      <= is_last ? '0 : cnt + 1'b1;
        end
    end

    // Single-entry result register; a new load wins over a concurrent drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_index <= '0;
            out_value <= 8'd0;
            out_fired <= 1'b0;
        end else if (in_fire && is_last) begin
            out_valid <= 1'b1;
            out_index <= fin_idx;
            out_value <= fin_val;
            out_fired <= |fin_val;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/perceptron_argmax.md
# perceptron_argmax

Downstream consumer of the combinational `perceptron` stage. It accepts one 8-bit perceptron output per handshake and applies a threshold (clamped-step) activation. Over each frame of `N_CLASSES` samples it tracks the winning class, then presents the winning index and value on a registered valid/ready output. It turns a bank of perceptron scores, time-multiplexed onto one perceptron instance, into a single classification result per frame.

## Interface
Parameters:
- `N_CLASSES`, 8: samples per frame. Legal range 2..256.
- `THRESH`, 8'd0: activation threshold. Samples below it are treated as 0.
- `IDX_W`, `$clog2(N_CLASSES)`: width of the class index. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous frame abort.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `in_data`  in  8  perceptron output, unsigned, already wrapped mod 256 by the perceptron.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_index`  out  IDX_W  winning class index.
- `out_value`  out  8  activated value of the winner.
- `out_fired`  out  1  1 if the winner's activated value is nonzero.

## Operation
- Activation: `act = (in_data >= THRESH) ? in_data : 8'd0`. Unsigned compare; no widening; `act` is 8 bits.
- Frame position counter `cnt`, range 0..N_CLASSES-1:
  - increments on each accepted sample;
  - wraps to 0 on acceptance at N_CLASSES-1.
- Running best register `best_val`/`best_idx` updates on an accepted sample when `cnt == 0` or `act > best_val`.
  - Strict greater-than, so ties keep the lowest index.
- Last sample (`cnt == N_CLASSES-1`) accepted: load the output registers from the final comparison, which includes this sample.
  - `out_index`, `out_value` and `out_fired = (final value != 0)` are loaded.
  - `out_valid` is set to 1.
  - `cnt` returns to 0.
- Output register is single-entry. It holds until a handshake; on handshake `out_valid` clears unless a new result loads in the same cycle.
- `in_ready = !(cnt == N_CLASSES-1 && out_valid && !out_ready)`.
  - Only the last sample of a frame stalls, and only while the previous result is unconsumed.
  - Combinational from `out_ready`; no other combinational input-to-output paths.
- `flush` (sync):
  - `cnt` goes to 0 and the running best is discarded.
  - A sample presented in the same cycle is dropped, and `in_ready` still reads as computed.
  - The output register and `out_valid` are unaffected.
- State summary:
  - ACC: `cnt < N_CLASSES-1`.
  - LAST: `cnt == N_CLASSES-1`, output free or draining → accept.
  - STALL: LAST with the output held → `in_ready = 0`.

## Timing
- Reset values (async assert, sync-safe deassert): `cnt = 0`, `best_val = 0`, `best_idx = 0`, `out_valid = 0`, `out_index = 0`, `out_value = 0`, `out_fired = 0`.
- `in_ready` is 1 out of reset.
- Latency: result is valid on the cycle after the last sample's handshake (1 cycle).
- Throughput: 1 sample/cycle sustained when the consumer holds `out_ready = 1`.
- Last-sample handshake and output handshake in the same cycle: the new result replaces the old; `out_valid` stays 1; no bubble.
- Reset mid-frame: the partial frame is lost and the pending result is lost. The first sample after reset is class 0.
- `out_*` data is stable while `out_valid && !out_ready`.

## Test plan
- Frame with N=8, THRESH=0, samples 3,9,2,9,1,0,7,5, `out_ready = 1` → one cycle after the 8th handshake: `out_valid = 1`, `out_index = 1`, `out_value = 9`, `out_fired = 1` (tie resolves to the lower index).
- THRESH=10, samples all 8'd9 → `out_index = 0`, `out_value = 0`, `out_fired = 0`.
- Back-to-back frames, `out_ready = 0` until the second frame's 8th sample is offered:
  - `in_ready = 0` only at `cnt = 7`; the first result holds stable.
  - Raise `out_ready` → in that cycle the first result is taken and the 8th sample is accepted; the next cycle shows the second result.
- `flush` asserted together with a sample at `cnt = 4` → that sample is dropped. The next accepted sample is class 0, and the prior `out_valid`/`out_*` are unchanged.
- Async `rst_n` low mid-frame (`cnt = 5`) with `out_valid = 1` → all outputs 0 immediately, `in_ready = 1`. A following full frame of 0,0,0,0,0,0,0,200 gives `out_index = 7`, `out_value = 200`.
- Random stress: 10k samples with random `in_valid`/`out_ready` against a scoreboard model. Check no result is lost or duplicated and that `out_*` holds while stalled.
